// File: rtl/simplecpu_pkg.sv
// Shared op-mode encoding, stage FSM states and mode-class helpers for the
// simple CPU pipeline.
package simplecpu_pkg;

  localparam logic [3:0] MODE_ADD     = 4'h1;
  localparam logic [3:0] MODE_SUB     = 4'h2;
  localparam logic [3:0] MODE_NAND    = 4'h3;
  localparam logic [3:0] MODE_SHL     = 4'h4;
  localparam logic [3:0] MODE_SHR     = 4'h5;
  localparam logic [3:0] MODE_OUT     = 4'h6;
  localparam logic [3:0] MODE_IN      = 4'h7;
  localparam logic [3:0] MODE_LOAD    = 4'hd;
  localparam logic [3:0] MODE_STORE   = 4'he;
  localparam logic [3:0] MODE_LOADIMM = 4'hf;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    OUT_WAIT  = 2'd2
  } state_t;

  // Arithmetic/logic ops are the only ones that update the ZN register.
  function automatic logic is_alu_mode(input logic [3:0] m);
    return (m >= MODE_ADD) && (m <= MODE_SHR);
  endfunction

  function automatic logic writes_rf(input logic [3:0] m);
    return is_alu_mode(m) || (m == MODE_IN) || (m == MODE_LOADIMM);
  endfunction

endpackage

// File: rtl/memwb_outbuf.sv
// Small synchronous FIFO for output-port data; DEPTH must be a power of two.
// A push into a full FIFO is honoured when a pop happens on the same edge.
module memwb_outbuf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: performs writeback, data-memory and output-port side effects of
// each ALU op and holds the ZN flags. MEMWB_OUTBUF_EN selects a FIFO OUT path.
// Handshake: an op transfers on a rising edge where ex_valid && ex_ready; the
// output port transfers on a rising edge where out_valid && out_ready.
module mem_wb_stage
  import simplecpu_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int REG_AW       = 2,
  parameter int MEM_AW       = 8,
  parameter int OUTBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_mode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [MEM_AW-1:0] ex_addr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [1:0]        ex_zn,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              dm_we,
  output logic              dm_re,
  output logic [MEM_AW-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        flags,
  output logic [1:0]        dbg_state_o
);

  state_t state_q;
  logic   accept, is_out;
  logic   [REG_AW-1:0] ld_rd_q;

  assign is_out      = (ex_mode == MODE_OUT);
  assign accept      = ex_valid && ex_ready;
  assign dbg_state_o = state_q;

`ifdef MEMWB_OUTBUF_EN
  logic fifo_full, fifo_empty;

  // A full FIFO still takes an OUT when the consumer drains its head this edge.
  assign ex_ready  = (state_q != LOAD_WAIT) && !(fifo_full && is_out && !out_ready);
  assign out_valid = !fifo_empty;

  memwb_outbuf #(
    .DEPTH (OUTBUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_outbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept && is_out),
    .data_i  (ex_result),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (out_data)
  );
`else
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  assign ex_ready  = (state_q == RUN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      dm_we    <= 1'b0;
      dm_re    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      flags    <= '0;
      ld_rd_q  <= '0;
`ifndef MEMWB_OUTBUF_EN
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
      dm_we <= 1'b0;
      dm_re <= 1'b0;
      case (state_q)
        RUN: if (accept) begin
          if (is_alu_mode(ex_mode)) flags <= ex_zn;
          if (writes_rf(ex_mode)) begin
            rf_we    <= 1'b1;
            rf_waddr <= ex_rd;
            rf_wdata <= ex_result;
          end
          if (ex_mode == MODE_STORE) begin
            dm_we    <= 1'b1;
            dm_addr  <= ex_addr;
            dm_wdata <= ex_result;
          end
          if (ex_mode == MODE_LOAD) begin
            dm_re   <= 1'b1;
            dm_addr <= ex_addr;
            ld_rd_q <= ex_rd;
            state_q <= LOAD_WAIT;
          end
`ifndef MEMWB_OUTBUF_EN
          if (is_out) begin
            out_data_q  <= ex_result;
            out_valid_q <= 1'b1;
            state_q     <= OUT_WAIT;
          end
`endif
        end
        // Read data is returned while dm_re is high; write it back to the
        // register latched at accept, not whatever ex_rd shows now.
        LOAD_WAIT: begin
          rf_we    <= 1'b1;
          rf_waddr <= ld_rd_q;
          rf_wdata <= dm_rdata;
          state_q  <= RUN;
        end
        OUT_WAIT: begin
`ifndef MEMWB_OUTBUF_EN
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= RUN;
          end
`else
          state_q <= RUN;
`endif
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus a randomized op stream checked
// against an event-queue model; build with MEMWB_OUTBUF_EN for the FIFO variant.
module tb_mem_wb_stage;
  import simplecpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid, ex_ready;
  logic [3:0] ex_mode;
  logic [7:0] ex_result, ex_addr;
  logic [1:0] ex_rd, ex_zn;
  logic       rf_we, dm_we, dm_re, out_valid, out_ready;
  logic [1:0] rf_waddr, flags, dbg_state;
  logic [7:0] rf_wdata, dm_addr, dm_wdata, dm_rdata, out_data;

  logic [7:0] tb_mem [256];
  assign dm_rdata = tb_mem[dm_addr];

  logic [39:0] all_outs;
  assign all_outs = {rf_we, rf_waddr, rf_wdata, dm_we, dm_re, dm_addr, dm_wdata,
                     out_valid, out_data, flags};

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mode(ex_mode), .ex_result(ex_result), .ex_addr(ex_addr), .ex_rd(ex_rd),
    .ex_zn(ex_zn), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flags(flags), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit rand_ready_en = 1'b0;
  logic [1:0]  model_flags = 2'b00;
  logic [9:0]  rf_exp_q[$];
  logic [15:0] dmw_exp_q[$];
  logic [7:0]  dmr_exp_q[$];
  logic [7:0]  out_exp_q[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: strobes are compared in order against the model's event queues.
  initial begin : monitor
    logic [9:0]  e10;
    logic [15:0] e16;
    logic [7:0]  e8;
    bit          hold_v;
    logic [7:0]  hold_d;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!(mon_en && rst_n)) begin
        hold_v = 1'b0;
      end else begin
        if (rf_we) begin
          n_vec++;
          if (rf_exp_q.size() == 0) begin
            n_err++; $display("FAIL rf_unexpected got %h expected none", {rf_waddr, rf_wdata});
          end else begin
            e10 = rf_exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== e10) begin
              n_err++; $display("FAIL rf_write got %h expected %h", {rf_waddr, rf_wdata}, e10);
            end
          end
        end
        if (dm_we) begin
          n_vec++;
          if (dmw_exp_q.size() == 0) begin
            n_err++; $display("FAIL dm_we_unexpected got %h expected none", {dm_addr, dm_wdata});
          end else begin
            e16 = dmw_exp_q.pop_front();
            if ({dm_addr, dm_wdata} !== e16) begin
              n_err++; $display("FAIL dm_write got %h expected %h", {dm_addr, dm_wdata}, e16);
            end
          end
        end
        if (dm_re) begin
          n_vec++;
          if (dmr_exp_q.size() == 0) begin
            n_err++; $display("FAIL dm_re_unexpected got %h expected none", dm_addr);
          end else begin
            e8 = dmr_exp_q.pop_front();
            if (dm_addr !== e8) begin
              n_err++; $display("FAIL dm_read_addr got %h expected %h", dm_addr, e8);
            end
          end
        end
        if (hold_v) begin
          n_vec++;
          if (out_valid !== 1'b1 || out_data !== hold_d) begin
            n_err++; $display("FAIL out_hold got v=%b d=%h expected v=1 d=%h", out_valid, out_data, hold_d);
          end
        end
        if (out_valid && out_ready) begin
          n_vec++;
          if (out_exp_q.size() == 0) begin
            n_err++; $display("FAIL out_unexpected got %h expected none", out_data);
          end else begin
            e8 = out_exp_q.pop_front();
            if (out_data !== e8) begin
              n_err++; $display("FAIL out_data got %h expected %h", out_data, e8);
            end
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        n_vec++;
        if (flags !== model_flags) begin
          n_err++; $display("FAIL flags got %b expected %b", flags, model_flags);
        end
      end
    end
  end

  // Reference model: the side effects each op must eventually produce.
  task automatic predict(input logic [3:0] m, input logic [7:0] res, input logic [7:0] a,
                         input logic [1:0] rd, input logic [1:0] zn);
    case (m)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin rf_exp_q.push_back({rd, res}); model_flags = zn; end
      4'h7, 4'hf: rf_exp_q.push_back({rd, res});
      4'he:       dmw_exp_q.push_back({a, res});
      4'hd:       begin dmr_exp_q.push_back(a); rf_exp_q.push_back({rd, tb_mem[a]}); end
      4'h6:       out_exp_q.push_back(res);
      default:    ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_op(input logic [3:0] m, input logic [7:0] res, input logic [7:0] a,
                          input logic [1:0] rd, input logic [1:0] zn, output int stall);
    stall = 0;
    ex_valid = 1'b1; ex_mode = m; ex_result = res; ex_addr = a; ex_rd = rd; ex_zn = zn;
    @(negedge clk);
    while (!ex_ready && stall < 50) begin
      @(negedge clk);
      stall++;
    end
    if (!ex_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout mode=%h got ex_ready=0 expected 1 within 50 cycles", m);
      ex_valid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      predict(m, res, a, rd, zn);
      #1;
      ex_valid = 1'b0;
    end
  endtask

  task automatic clear_model();
    rf_exp_q.delete(); dmw_exp_q.delete(); dmr_exp_q.delete(); out_exp_q.delete();
    model_flags = 2'b00;
  endtask

  task automatic test_reset();
    int st;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (all_outs !== 40'd0 || ex_ready !== 1'b1 || dbg_state !== RUN) begin
      n_err++; $display("FAIL reset_values got outs=%h rdy=%b st=%0d expected 0/1/0", all_outs, ex_ready, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mode = MODE_LOAD; ex_addr = 8'h40; ex_rd = 2'd1; ex_result = '0; ex_zn = '0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    n_vec++;
    if (dm_re !== 1'b1 || dbg_state !== LOAD_WAIT) begin
      n_err++; $display("FAIL reset_load_start got dm_re=%b st=%0d expected 1/%0d", dm_re, dbg_state, LOAD_WAIT);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== 40'd0 || ex_ready !== 1'b1 || dbg_state !== RUN) begin
      n_err++; $display("FAIL reset_mid_load got outs=%h rdy=%b st=%0d expected 0/1/0", all_outs, ex_ready, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_model();
    mon_en = 1'b1;
    @(posedge clk); #1;
    drive_op(MODE_ADD, 8'h05, 8'h00, 2'd2, 2'b00, st);
    n_vec++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd2, 8'h05}) begin
      n_err++; $display("FAIL reset_then_add got %b/%0d/%h expected 1/2/05", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_flags();
    int st;
    drive_op(MODE_SUB, 8'hFB, 8'h00, 2'd1, 2'b01, st);
    n_vec++;
    if ({rf_we, rf_wdata, flags} !== {1'b1, 8'hFB, 2'b01}) begin
      n_err++; $display("FAIL sub_flags got we=%b d=%h f=%b expected 1/FB/01", rf_we, rf_wdata, flags);
    end
    drive_op(MODE_LOADIMM, 8'h10, 8'h00, 2'd3, 2'b10, st);
    n_vec++;
    if ({rf_we, rf_waddr, rf_wdata, flags, st} !== {1'b1, 2'd3, 8'h10, 2'b01, 32'd0}) begin
      n_err++; $display("FAIL loadimm_flags got we=%b a=%0d d=%h f=%b stall=%0d expected 1/3/10/01/0",
                        rf_we, rf_waddr, rf_wdata, flags, st);
    end
  endtask

  task automatic test_store();
    int st;
    drive_op(MODE_STORE, 8'h2A, 8'h40, 2'd0, 2'b11, st);
    n_vec++;
    if ({dm_we, dm_addr, dm_wdata, rf_we} !== {1'b1, 8'h40, 8'h2A, 1'b0}) begin
      n_err++; $display("FAIL store got we=%b a=%h d=%h rf_we=%b expected 1/40/2A/0", dm_we, dm_addr, dm_wdata, rf_we);
    end
    @(posedge clk); #1;
    n_vec++;
    if (dm_we !== 1'b0) begin
      n_err++; $display("FAIL store_pulse got dm_we=%b expected 0", dm_we);
    end
  endtask

  task automatic test_load();
    int st;
    tb_mem[8'h40] = 8'h2A;
    drive_op(MODE_LOAD, 8'h00, 8'h40, 2'd1, 2'b00, st);
    n_vec++;
    if ({dm_re, dm_addr, ex_ready, rf_we} !== {1'b1, 8'h40, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL load_issue got re=%b a=%h rdy=%b rf_we=%b expected 1/40/0/0", dm_re, dm_addr, ex_ready, rf_we);
    end
    fork
      drive_op(MODE_ADD, 8'h03, 8'h00, 2'd2, 2'b00, st);
      begin
        @(posedge clk); #1;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, dm_re} !== {1'b1, 2'd1, 8'h2A, 1'b0}) begin
          n_err++; $display("FAIL load_wb got we=%b a=%0d d=%h re=%b expected 1/1/2A/0", rf_we, rf_waddr, rf_wdata, dm_re);
        end
      end
    join
    n_vec++;
    if (st !== 1) begin
      n_err++; $display("FAIL load_stall got %0d cycles expected 1", st);
    end
  endtask

`ifndef MEMWB_OUTBUF_EN
  task automatic test_out();
    int st;
    out_ready = 1'b0;
    drive_op(MODE_OUT, 8'h81, 8'h00, 2'd0, 2'b00, st);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({out_valid, out_data, ex_ready} !== {1'b1, 8'h81, 1'b0}) begin
        n_err++; $display("FAIL out_wait[%0d] got v=%b d=%h rdy=%b expected 1/81/0", i, out_valid, out_data, ex_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, ex_ready} !== 2'b01 || out_exp_q.size() != 0) begin
      n_err++; $display("FAIL out_release got v=%b rdy=%b pending=%0d expected 0/1/0", out_valid, ex_ready, out_exp_q.size());
    end
  endtask
`else
  task automatic test_outbuf();
    int st;
    out_ready = 1'b0;
    drive_op(MODE_OUT, 8'h11, 8'h00, 2'd0, 2'b00, st);
    drive_op(MODE_OUT, 8'h22, 8'h00, 2'd0, 2'b00, st);
    n_vec++;
    if (st !== 0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_err++; $display("FAIL outbuf_fill got stall=%0d v=%b d=%h expected 0/1/11", st, out_valid, out_data);
    end
    fork
      drive_op(MODE_OUT, 8'h33, 8'h00, 2'd0, 2'b00, st);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n_vec++;
    if (st < 3) begin
      n_err++; $display("FAIL outbuf_stall got %0d cycles expected >=3", st);
    end
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out_exp_q.size() != 0) begin
      n_err++; $display("FAIL outbuf_drain got v=%b pending=%0d expected 0/0", out_valid, out_exp_q.size());
    end
  endtask
`endif

  task automatic test_random();
    int st;
    logic [3:0] m;
    rand_ready_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      m = 4'($urandom_range(0, 15));
      drive_op(m, 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), st);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (rf_exp_q.size() + dmw_exp_q.size() + dmr_exp_q.size() + out_exp_q.size() != 0) begin
      n_err++; $display("FAIL random_drain got rf=%0d dmw=%0d dmr=%0d out=%0d pending expected all 0",
                        rf_exp_q.size(), dmw_exp_q.size(), dmr_exp_q.size(), out_exp_q.size());
    end
    n_vec++;
    if (ex_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== RUN) begin
      n_err++; $display("FAIL random_idle got rdy=%b v=%b st=%0d expected 1/0/0", ex_ready, out_valid, dbg_state);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom);
    rst_n = 1'b0; ex_valid = 1'b0; ex_mode = '0; ex_result = '0; ex_addr = '0;
    ex_rd = '0; ex_zn = '0; out_ready = 1'b0;
    test_reset();
    test_flags();
    test_store();
    test_load();
`ifdef MEMWB_OUTBUF_EN
    test_outbuf();
`else
    test_out();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
